// File: rtl/mem_responder_if.sv
// Memory-port bundle between an initiator (datapath) and mem_responder.
interface mem_responder_if;
    logic        Req;
    logic        Wr;
    logic [31:0] Address;
    logic [31:0] Datain;
    logic [31:0] Dataout;
    logic        Ack;
    logic        Err;
    logic        Busy;

    modport master (output Req, Wr, Address, Datain,
                    input  Dataout, Ack, Err, Busy);
    modport slave  (input  Req, Wr, Address, Datain,
                    output Dataout, Ack, Err, Busy);
endinterface

// File: rtl/mem_responder.sv
// Word-addressed memory slave with Req/Ack handshake, programmable wait states
// and rejection of misaligned or out-of-range addresses.
module mem_responder #(
    parameter int unsigned ADDR_WIDTH  = 8,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic            Clk,
    input  logic            Reset,
    mem_responder_if.slave  bus
);
    localparam int unsigned DATA_W = 32;
    localparam int unsigned DEPTH  = 1 << ADDR_WIDTH;
    localparam int unsigned CNT_W  = 4;

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

    typedef struct packed {
        logic                  wr;
        logic [ADDR_WIDTH-1:0] idx;
        logic [DATA_W-1:0]     data;
    } req_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    req_t                req_q, req_d;
    logic                pend_err_q, pend_err_d;
    logic [DATA_W-1:0]   dout_q, dout_d;
    logic                ack_q, ack_d;
    logic                err_q, err_d;
    logic                busy_q, busy_d;
    logic                mem_we_c;
    logic                legal_c;
    logic [DATA_W-1:0]   mem_q [DEPTH];

    assign legal_c = (bus.Address[1:0] == 2'b00) &&
                     (bus.Address[DATA_W-1:ADDR_WIDTH+2] == '0);

    // Next-state and output decode
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        req_d      = req_q;
        pend_err_d = pend_err_q;
        dout_d     = dout_q;
        ack_d      = 1'b0;
        err_d      = 1'b0;
        mem_we_c   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.Req) begin
                    req_d.wr   = bus.Wr;
                    req_d.idx  = bus.Address[ADDR_WIDTH+1:2];
                    req_d.data = bus.Datain;
                    if (legal_c) begin
                        state_d    = ST_WAIT;
                        cnt_d      = CNT_W'(WAIT_CYCLES);
                        pend_err_d = 1'b0;
                    end else begin
                        state_d    = ST_RESP;
                        pend_err_d = 1'b1;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    state_d = ST_RESP;
                    ack_d   = 1'b1;
                    if (req_q.wr) mem_we_c = 1'b1;
                    else          dout_d   = mem_q[req_q.idx];
                end
            end
            ST_RESP: begin
                // Rejected accesses arrive here with Ack still low and pulse it now.
                if (ack_q) begin
                    state_d = ST_IDLE;
                end else begin
                    ack_d = 1'b1;
                    err_d = pend_err_q;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            req_q      <= '0;
            pend_err_q <= 1'b0;
            dout_q     <= '0;
            ack_q      <= 1'b0;
            err_q      <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            req_q      <= req_d;
            pend_err_q <= pend_err_d;
            dout_q     <= dout_d;
            ack_q      <= ack_d;
            err_q      <= err_d;
            busy_q     <= busy_d;
        end
    end

    // Storage array, cleared by reset
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
        end else if (mem_we_c) begin
            mem_q[req_q.idx] <= req_q.data;
        end
    end

    assign bus.Dataout = dout_q;
    assign bus.Ack     = ack_q;
    assign bus.Err     = err_q;
    assign bus.Busy    = busy_q;
endmodule

// File: tb/tb_mem_responder.sv
// Randomised bench for mem_responder: two instances (2 and 0 wait states)
// checked against a word-array reference model.
module tb_mem_responder;
    localparam int unsigned AW    = 8;
    localparam int unsigned DEPTH = 1 << AW;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    logic [31:0] mdl   [2][DEPTH];
    logic [31:0] mdout [2];

    mem_responder_if bus2 ();
    mem_responder_if bus0 ();

    mem_responder #(.ADDR_WIDTH(AW), .WAIT_CYCLES(2)) dut2 (.Clk(clk), .Reset(rst_n), .bus(bus2));
    mem_responder #(.ADDR_WIDTH(AW), .WAIT_CYCLES(0)) dut0 (.Clk(clk), .Reset(rst_n), .bus(bus0));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive(input int s, input logic req, input logic wr,
                         input logic [31:0] addr, input logic [31:0] data);
        if (s == 0) begin
            bus0.Req = req; bus0.Wr = wr; bus0.Address = addr; bus0.Datain = data;
        end else begin
            bus2.Req = req; bus2.Wr = wr; bus2.Address = addr; bus2.Datain = data;
        end
    endtask

    function automatic logic get_ack(input int s);
        return (s == 0) ? bus0.Ack : bus2.Ack;
    endfunction
    function automatic logic get_err(input int s);
        return (s == 0) ? bus0.Err : bus2.Err;
    endfunction
    function automatic logic get_busy(input int s);
        return (s == 0) ? bus0.Busy : bus2.Busy;
    endfunction
    function automatic logic [31:0] get_dout(input int s);
        return (s == 0) ? bus0.Dataout : bus2.Dataout;
    endfunction

    function automatic void clear_model();
        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < int'(DEPTH); i++) mdl[s][i] = '0;
            mdout[s] = '0;
        end
    endfunction

    // One transaction on instance s (0: no wait states, 1: two wait states).
    // Called at a negedge; returns at a negedge with that instance idle.
    task automatic access(input int s, input logic wr, input logic [31:0] addr,
                          input logic [31:0] data, input bit hold);
        bit   legal;
        int   n;
        int   idx;
        int   exp_lat;
        legal   = (addr[1:0] == 2'b00) && (addr < 32'(4 * DEPTH));
        idx     = int'(addr[AW+1:2]);
        exp_lat = legal ? ((s == 0) ? 1 : 3) : 1;
        drive(1 - s, 1'b0, 1'b0, '0, '0);
        drive(s, 1'b1, wr, addr, data);
        @(negedge clk);
        check("busy_after_accept", 32'(get_busy(s)), 32'd1);
        check("ack_at_accept", 32'(get_ack(s)), 32'd0);
        drive(s, hold, 1'($urandom), $urandom, $urandom);
        n = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (get_ack(s)) begin
                n = i;
                break;
            end
        end
        check("ack_latency", 32'(n), 32'(exp_lat));
        if (legal && wr)  mdl[s][idx] = data;
        if (legal && !wr) mdout[s] = mdl[s][idx];
        check("err", 32'(get_err(s)), legal ? 32'd0 : 32'd1);
        check("dataout", get_dout(s), mdout[s]);
        @(negedge clk);
        check("ack_one_cycle", 32'(get_ack(s)), 32'd0);
        check("busy_back_idle", 32'(get_busy(s)), 32'd0);
        check("dataout_held", get_dout(s), mdout[s]);
    endtask

    initial begin
        logic [31:0] a;
        n_checks = 0;
        n_errors = 0;
        clear_model();
        rst_n = 1'b0;
        drive(0, 1'b0, 1'b0, '0, '0);
        drive(1, 1'b0, 1'b0, '0, '0);
        repeat (3) @(negedge clk);
        check("rst_ack", 32'(bus2.Ack), 32'd0);
        check("rst_err", 32'(bus2.Err), 32'd0);
        check("rst_busy", 32'(bus2.Busy), 32'd0);
        check("rst_dout", bus2.Dataout, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed: write, read-back, unwritten word
        access(1, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0);
        access(1, 1'b0, 32'h10, 32'h0, 1'b0);
        access(1, 1'b0, 32'h14, 32'h0, 1'b0);
        // Misaligned and out-of-range rejections leave storage and Dataout alone
        access(1, 1'b0, 32'h10, 32'h0, 1'b0);
        access(1, 1'b1, 32'h12, 32'h11111111, 1'b0);
        access(1, 1'b1, 32'h400, 32'h22222222, 1'b0);
        access(1, 1'b0, 32'h401, 32'h0, 1'b0);
        access(1, 1'b0, 32'h10, 32'h0, 1'b0);
        access(1, 1'b1, 32'h3FC, 32'hCAFEF00D, 1'b0);
        access(1, 1'b0, 32'h3FC, 32'h0, 1'b0);
        access(1, 1'b0, 32'h8000_0000, 32'h0, 1'b0);
        // Zero wait states
        access(0, 1'b1, 32'h40, 32'hA5A5A5A5, 1'b0);
        access(0, 1'b0, 32'h40, 32'h0, 1'b0);
        access(0, 1'b0, 32'h400, 32'h0, 1'b0);
        // Req held high across back-to-back reads with inputs scrambled mid-flight
        access(1, 1'b1, 32'h30, 32'h12345678, 1'b0);
        access(1, 1'b0, 32'h30, 32'h0, 1'b1);
        access(1, 1'b0, 32'h10, 32'h0, 1'b1);
        access(1, 1'b0, 32'h30, 32'h0, 1'b0);

        // Reset in the middle of a write's wait states
        drive(1, 1'b1, 1'b1, 32'h20, 32'hFEEDFACE);
        @(negedge clk);
        drive(1, 1'b0, 1'b0, '0, '0);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_ack", 32'(bus2.Ack), 32'd0);
        check("midrst_busy", 32'(bus2.Busy), 32'd0);
        check("midrst_dout", bus2.Dataout, 32'd0);
        clear_model();
        @(negedge clk);
        rst_n = 1'b1;
        begin
            int spurious;
            spurious = 0;
            repeat (6) begin
                @(negedge clk);
                if (bus2.Ack || bus0.Ack) spurious++;
            end
            check("no_spurious_ack", 32'(spurious), 32'd0);
        end
        access(1, 1'b0, 32'h20, 32'h0, 1'b0);
        access(1, 1'b0, 32'h10, 32'h0, 1'b0);

        // Random traffic against the model
        for (int t = 0; t < 300; t++) begin
            case ($urandom_range(0, 4))
                0, 1:    a = 32'($urandom_range(0, 15)) << 2;
                2:       a = 32'($urandom_range(0, DEPTH - 1)) << 2;
                3:       a = (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(1, 3));
                default: a = $urandom | 32'h400;
            endcase
            access(int'($urandom_range(0, 1)), 1'($urandom), a, $urandom, bit'($urandom_range(0, 1)));
        end
        drive(0, 1'b0, 1'b0, '0, '0);
        drive(1, 1'b0, 1'b0, '0, '0);
        repeat (2) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
